uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Configurable UART transmitter. It sends a start bit, then
//                DATA_BITS data bits LSB first, an optional even or odd
//                parity bit, and 1 or 2 stop bits. Each bit lasts
//                CLKS_PER_BIT clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dataValid,
    input  logic [DATA_BITS-1:0] inputByte,
    output logic                 oReady,
    output logic                 serial,
    output logic                 oActive,
    output logic                 oDone
);

    // The bit counter must hold CLKS_PER_BIT-1. It is at least 1 bit wide so
    // that CLKS_PER_BIT=1 still gives a legal vector.
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = $clog2(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);
    localparam logic               c_stop_last = (STOP_BITS == 2);

    // Reject configurations the datapath cannot represent.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                 state_q,    state_d;
    logic [c_cnt_w-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [c_idx_w-1:0]     data_idx_q, data_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   data_q,     data_d;
    logic                   bit_end;
    logic                   parity_bit;

    assign bit_end    = (bit_cnt_q == c_bit_last);
    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

    // State and datapath registers. The async reset returns the line to idle
    // at once, because serial is decoded directly from state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            data_idx_q <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_idx_q <= data_idx_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
        end
    end

    // Next-state sequencing and per-state output decode.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_idx_d = data_idx_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        oReady     = 1'b0;
        serial     = 1'b1;
        oActive    = 1'b0;
        oDone      = 1'b0;

        // Every bit period ends by clearing the counter; otherwise it counts up.
        if (bit_end) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                oReady     = 1'b1;
                oDone      = (state_q == DONE);
                bit_cnt_d  = '0;
                data_idx_d = '0;
                stop_cnt_d = 1'b0;
                if (dataValid) begin
                    data_d  = inputByte;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                oActive = 1'b1;
                serial  = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                oActive = 1'b1;
                serial  = data_q[data_idx_q];
                if (bit_end) begin
                    if (data_idx_q == c_idx_last) begin
                        data_idx_d = '0;
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        data_idx_d = data_idx_q + c_idx_w'(1);
                    end
                end
            end
            PARITY: begin
                oActive = 1'b1;
                serial  = parity_bit;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                oActive = 1'b1;
                if (bit_end) begin
                    if (stop_cnt_q == c_stop_last) begin
                        stop_cnt_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                // Unused encodings recover to idle with the counters cleared.
                state_d    = IDLE;
                bit_cnt_d  = '0;
                data_idx_d = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
